// File: rtl/mt9p031_pkg.sv
// Shared definitions for the MT9P031 frame-gate stage: FSM encoding and counter width default.
package mt9p031_pkg;

    localparam int CNT_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACTIVE = 2'd2
    } gate_state_e;

endpackage

// File: rtl/mt9p031_line_meter.sv
// Per-frame line geometry meter: pixels per line, lines per frame, line-length consistency.
module mt9p031_line_meter
    import mt9p031_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk_sensor_pix,
    input  logic                 reset_sensor_n,
    input  logic                 frame_start,
    input  logic                 active,
    input  logic                 gate,
    input  logic                 lval,
    input  logic                 lval_d,
    output logic                 line_end,
    output logic [CNT_WIDTH-1:0] pix_cnt,
    output logic [CNT_WIDTH-1:0] lines_total,
    output logic                 err_total
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] line_cnt;
    logic [CNT_WIDTH-1:0] ref_len;
    logic                 err_sticky;
    logic                 first_line;
    logic                 len_mismatch;
    logic                 pix_inc;

    assign line_end     = active & lval_d & ~lval;
    assign first_line   = (line_cnt == '0);
    assign len_mismatch = line_end & ~first_line & (pix_cnt != ref_len);
    assign pix_inc      = gate & lval;

    // Combined values let a line end on the frame-end edge be reported with that frame.
    assign lines_total = !line_end            ? line_cnt :
                         (line_cnt == CNT_MAX) ? CNT_MAX  : line_cnt + CNT_ONE;
    assign err_total   = err_sticky | len_mismatch;

    always_ff @(posedge clk_sensor_pix or negedge reset_sensor_n) begin
        if (!reset_sensor_n) begin
            pix_cnt    <= '0;
            line_cnt   <= '0;
            ref_len    <= '0;
            err_sticky <= 1'b0;
        end else if (frame_start) begin
            pix_cnt    <= pix_inc ? CNT_ONE : '0;
            line_cnt   <= '0;
            ref_len    <= '0;
            err_sticky <= 1'b0;
        end else if (line_end) begin
            pix_cnt  <= '0;
            line_cnt <= lines_total;
            if (first_line)
                ref_len <= pix_cnt;
            if (len_mismatch)
                err_sticky <= 1'b1;
        end else if (pix_inc && pix_cnt != CNT_MAX) begin
            pix_cnt <= pix_cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/mt9p031_frame_gate.sv
// Forwards only complete, enabled MT9P031 frames and reports their line/frame geometry.
module mt9p031_frame_gate
    import mt9p031_pkg::*;
#(
    parameter int SENSOR_DAT_WIDTH = 10,
    parameter int CNT_WIDTH        = CNT_WIDTH_DEF
) (
    input  logic                        clk_sensor_pix,
    input  logic                        reset_sensor_n,
    input  logic                        i_stream_enable,
    input  logic                        i_fval,
    input  logic                        i_lval,
    input  logic [SENSOR_DAT_WIDTH-1:0] iv_pix_data,
    output logic                        o_fval,
    output logic                        o_lval,
    output logic [SENSOR_DAT_WIDTH-1:0] ov_pix_data,
    output logic                        o_frame_done,
    output logic [CNT_WIDTH-1:0]        ov_line_pix,
    output logic [CNT_WIDTH-1:0]        ov_frame_lines,
    output logic                        o_line_len_err
);

    gate_state_e          state, state_nxt;
    logic                 fval_d, lval_d;
    logic                 rise, fall;
    logic                 gate, frame_start, frame_end;
    logic                 line_end;
    logic [CNT_WIDTH-1:0] pix_cnt;
    logic [CNT_WIDTH-1:0] lines_total;
    logic                 err_total;

    assign rise = i_fval & ~fval_d;
    assign fall = ~i_fval & fval_d;

    always_ff @(posedge clk_sensor_pix or negedge reset_sensor_n) begin
        if (!reset_sensor_n) begin
            state  <= S_IDLE;
            fval_d <= 1'b0;
            lval_d <= 1'b0;
        end else begin
            state  <= state_nxt;
            fval_d <= i_fval;
            lval_d <= i_lval;
        end
    end

    // S_IDLE waits for fval low so a frame already running at reset release is never half-forwarded.
    always_comb begin
        state_nxt   = state;
        gate        = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!i_fval)
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (rise && i_stream_enable) begin
                    state_nxt   = S_ACTIVE;
                    frame_start = 1'b1;
                    gate        = 1'b1;
                end
            end
            S_ACTIVE: begin
                gate = i_fval;
                if (fall) begin
                    state_nxt = S_WAIT;
                    frame_end = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    mt9p031_line_meter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_line_meter (
        .clk_sensor_pix (clk_sensor_pix),
        .reset_sensor_n (reset_sensor_n),
        .frame_start    (frame_start),
        .active         (state == S_ACTIVE),
        .gate           (gate),
        .lval           (i_lval),
        .lval_d         (lval_d),
        .line_end       (line_end),
        .pix_cnt        (pix_cnt),
        .lines_total    (lines_total),
        .err_total      (err_total)
    );

    always_ff @(posedge clk_sensor_pix or negedge reset_sensor_n) begin
        if (!reset_sensor_n) begin
            o_fval         <= 1'b0;
            o_lval         <= 1'b0;
            ov_pix_data    <= '0;
            o_frame_done   <= 1'b0;
            ov_line_pix    <= '0;
            ov_frame_lines <= '0;
            o_line_len_err <= 1'b0;
        end else begin
            o_fval       <= gate;
            o_lval       <= gate & i_lval;
            ov_pix_data  <= (gate & i_lval) ? iv_pix_data : '0;
            o_frame_done <= frame_end;
            if (line_end)
                ov_line_pix <= pix_cnt;
            if (frame_end) begin
                ov_frame_lines <= lines_total;
                o_line_len_err <= err_total;
            end
        end
    end

endmodule

// File: tb/tb_mt9p031_frame_gate.sv
// Directed plus randomized frames against a frame-level reference model; two widths share stimulus.
module tb_mt9p031_frame_gate;

    logic        clk = 1'b0;
    logic        reset_sensor_n;
    logic        i_stream_enable;
    logic        i_fval;
    logic        i_lval;
    logic [9:0]  iv_pix_data;

    logic        o_fval, o_lval, o_frame_done, o_line_len_err;
    logic [9:0]  ov_pix_data;
    logic [15:0] ov_line_pix, ov_frame_lines;

    logic        o_fval4, o_lval4, o_frame_done4, o_line_len_err4;
    logic [9:0]  ov_pix_data4;
    logic [3:0]  ov_line_pix4, ov_frame_lines4;

    always #5 clk = ~clk;

    mt9p031_frame_gate u_dut (
        .clk_sensor_pix  (clk),
        .reset_sensor_n  (reset_sensor_n),
        .i_stream_enable (i_stream_enable),
        .i_fval          (i_fval),
        .i_lval          (i_lval),
        .iv_pix_data     (iv_pix_data),
        .o_fval          (o_fval),
        .o_lval          (o_lval),
        .ov_pix_data     (ov_pix_data),
        .o_frame_done    (o_frame_done),
        .ov_line_pix     (ov_line_pix),
        .ov_frame_lines  (ov_frame_lines),
        .o_line_len_err  (o_line_len_err)
    );

    mt9p031_frame_gate #(.SENSOR_DAT_WIDTH(10), .CNT_WIDTH(4)) u_dut4 (
        .clk_sensor_pix  (clk),
        .reset_sensor_n  (reset_sensor_n),
        .i_stream_enable (i_stream_enable),
        .i_fval          (i_fval),
        .i_lval          (i_lval),
        .iv_pix_data     (iv_pix_data),
        .o_fval          (o_fval4),
        .o_lval          (o_lval4),
        .ov_pix_data     (ov_pix_data4),
        .o_frame_done    (o_frame_done4),
        .ov_line_pix     (ov_line_pix4),
        .ov_frame_lines  (ov_frame_lines4),
        .o_line_len_err  (o_line_len_err4)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model state: held geometry results and whether the gate is armed.
    int lens[32];
    int e_lp, e_fl, e_lp4, e_fl4;
    bit e_err, e_err4;
    bit armed;

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_held(input string tag);
        chk({tag, ".line_pix"},    32'(ov_line_pix),     32'(e_lp));
        chk({tag, ".frame_lines"}, 32'(ov_frame_lines),  32'(e_fl));
        chk({tag, ".len_err"},     32'(o_line_len_err),  32'(e_err));
        chk({tag, ".line_pix4"},   32'(ov_line_pix4),    32'(e_lp4));
        chk({tag, ".frame_lines4"},32'(ov_frame_lines4), 32'(e_fl4));
        chk({tag, ".len_err4"},    32'(o_line_len_err4), 32'(e_err4));
    endtask

    task automatic cyc(input logic fv, input logic lv, input bit fwd, input bit done);
        logic [9:0] d;
        logic       g;
        d = 10'($urandom);
        i_fval = fv;
        i_lval = lv;
        iv_pix_data = d;
        @(posedge clk);
        #1;
        g = fwd & fv;
        chk("o_fval",  32'(o_fval),       32'(g));
        chk("o_lval",  32'(o_lval),       32'(g & lv));
        chk("pix",     32'(ov_pix_data),  (g & lv) ? 32'(d) : 32'd0);
        chk("done",    32'(o_frame_done), 32'(done));
        chk("o_lval4", 32'(o_lval4),      32'(g & lv));
        chk("done4",   32'(o_frame_done4),32'(done));
    endtask

    // One sensor frame: fval porch, nl lines of lens[] px, fval/lval falling together on the last line.
    task automatic frame(input int nl, input bit en, input int drop_line, input int rst_line);
        bit fwd;
        fwd = en & armed;
        i_stream_enable = en;
        repeat (2) cyc(1'b1, 1'b0, fwd, 1'b0);
        for (int l = 0; l < nl; l++) begin
            for (int p = 0; p < lens[l]; p++) begin
                if (l == drop_line && p == lens[l] / 2)
                    i_stream_enable = 1'b0;
                if (l == rst_line && p == 2) begin
                    reset_sensor_n = 1'b0;
                    #1;
                    e_lp = 0; e_fl = 0; e_err = 0; e_lp4 = 0; e_fl4 = 0; e_err4 = 0;
                    chk("rst_mid.o_fval", 32'(o_fval),       32'd0);
                    chk("rst_mid.o_lval", 32'(o_lval),       32'd0);
                    chk("rst_mid.pix",    32'(ov_pix_data),  32'd0);
                    check_held("rst_mid");
                    #1;
                    reset_sensor_n = 1'b1;
                    fwd = 1'b0;
                    armed = 1'b0;
                end
                cyc(1'b1, 1'b1, fwd, 1'b0);
            end
            if (l < nl - 1)
                repeat (2) cyc(1'b1, 1'b0, fwd, 1'b0);
        end
        cyc(1'b0, 1'b0, fwd, fwd);
        armed = 1'b1;
        if (fwd) begin
            e_fl   = sat(nl, 16);
            e_fl4  = sat(nl, 4);
            e_lp   = sat(lens[nl-1], 16);
            e_lp4  = sat(lens[nl-1], 4);
            e_err  = 1'b0;
            e_err4 = 1'b0;
            for (int l = 1; l < nl; l++) begin
                if (sat(lens[l], 16) != sat(lens[0], 16)) e_err  = 1'b1;
                if (sat(lens[l], 4)  != sat(lens[0], 4))  e_err4 = 1'b1;
            end
        end
        check_held("frame_end");
        repeat (3) cyc(1'b0, 1'($urandom), 1'b0, 1'b0);
        check_held("idle");
    endtask

    task automatic set_lens(input int nl, input int len);
        for (int l = 0; l < nl; l++) lens[l] = len;
    endtask

    initial begin
        int nl, base;
        bit en;
        reset_sensor_n  = 1'b0;
        i_stream_enable = 1'b0;
        i_fval          = 1'b0;
        i_lval          = 1'b0;
        iv_pix_data     = '0;
        armed = 1'b0;
        e_lp = 0; e_fl = 0; e_err = 0; e_lp4 = 0; e_fl4 = 0; e_err4 = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset.o_fval", 32'(o_fval),       32'd0);
        chk("reset.o_lval", 32'(o_lval),       32'd0);
        chk("reset.pix",    32'(ov_pix_data),  32'd0);
        chk("reset.done",   32'(o_frame_done), 32'd0);
        check_held("reset");
        reset_sensor_n = 1'b1;
        armed = 1'b1;
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Basic 4 x 8 frame
        set_lens(4, 8);
        frame(4, 1'b1, -1, -1);

        // Reset mid-frame: remainder dropped, next frame forwarded
        frame(4, 1'b1, -1, 1);
        frame(4, 1'b1, -1, -1);

        // Enable low at fval rise: dropped
        set_lens(3, 5);
        frame(3, 1'b0, -1, -1);

        // Enable falls in line 2: frame completes, next is dropped
        set_lens(4, 8);
        frame(4, 1'b1, 1, -1);
        frame(4, 1'b0, -1, -1);

        // Line-length mismatch, then clean frame
        lens[0] = 8; lens[1] = 8; lens[2] = 7; lens[3] = 8;
        frame(4, 1'b1, -1, -1);
        set_lens(4, 8);
        frame(4, 1'b1, -1, -1);

        // Saturation on the 4-bit instance
        lens[0] = 20;
        frame(1, 1'b1, -1, -1);

        // lval pulses with fval low
        repeat (5) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check_held("lval_no_fval");

        // Randomized frames
        for (int f = 0; f < 10; f++) begin
            nl   = $urandom_range(1, 6);
            base = $urandom_range(1, 20);
            en   = ($urandom_range(0, 3) != 0);
            for (int l = 0; l < nl; l++)
                lens[l] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : base;
            frame(nl, en, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
